// File: rtl/timer_ctrl.sv
// Start/stop/pause timer controller driving a four-digit BCD up/down counter chain.
// Optional blinking alarm in DONE is enabled by defining TIMER_CTRL_ALARM_EN.
module timer_ctrl #(
  parameter int unsigned PRESC_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       mode,
  input  logic       digits_zero,
  input  logic       digits_max,
  output logic       cnt_en,
  output logic       dir_up,
  output logic       dir_down,
  output logic       load,
  output logic [1:0] state,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int unsigned PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          presc_wrap;
  logic          terminal;
  logic          start_term;
  logic          cnt_en_d;
  logic          dir_up_q, dir_up_d;

  assign presc_wrap = (presc_q == PRESC_LAST);
  // Terminal uses the latched direction in RUN, the live mode when starting from IDLE.
  assign terminal   = dir_up_q ? digits_max : digits_zero;
  assign start_term = mode ? digits_max : digits_zero;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cnt_en_d = 1'b0;
    dir_up_d = dir_up_q;

    unique case (state_q)
      IDLE: begin
        dir_up_d = mode;
        presc_d  = '0;
        if (start_stop) begin
          state_d = start_term ? DONE : RUN;
        end
      end

      RUN: begin
        if (terminal) begin
          state_d = DONE;
          presc_d = '0;
        end else if (start_stop) begin
          // Pause edge still counts, but a wrap here is deferred so no tick is lost.
          state_d = PAUSE;
          if (!presc_wrap) begin
            presc_d = presc_q + 1'b1;
          end
        end else begin
          presc_d  = presc_wrap ? '0 : presc_q + 1'b1;
          cnt_en_d = presc_wrap;
        end
      end

      PAUSE: begin
        if (start_stop) begin
          state_d = RUN;
        end
      end

      DONE: begin
`ifdef TIMER_CTRL_ALARM_EN
        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
`endif
        if (start_stop) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d  = IDLE;
      presc_d  = '0;
      cnt_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      cnt_en   <= 1'b0;
      load     <= 1'b1;
      dir_up_q <= 1'b1;
      dir_down <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_en   <= cnt_en_d;
      load     <= (state_d == IDLE);
      dir_up_q <= dir_up_d;
      dir_down <= ~dir_up_d;
      done     <= (state_d == DONE);
    end
  end

  assign state  = state_q;
  assign dir_up = dir_up_q;

`ifdef TIMER_CTRL_ALARM_EN
  logic alarm_d;

  always_comb begin
    alarm_d = alarm;
    if (state_d != DONE) begin
      alarm_d = 1'b0;
    end else if (state_q != DONE) begin
      alarm_d = 1'b1;
    end else if (presc_wrap) begin
      alarm_d = ~alarm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
    end else begin
      alarm <= alarm_d;
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule
